cache_tag_lru: RTL and testbench
================================

Name: cache_tag_lru

Overview:
- Tag/valid/LRU store for the 4-way fully associative cache; directly upstream of the cache write-enable selector.
- Compares the incoming address against all stored tags and drives the per-way vectors consumed downstream: hit, valido and lruBit.
- On each accepted access, updates the tag, valid and age state of the selected way.
- Contains a sequential flush engine that invalidates one way per cycle.

Parameters:
- ADDR_W, 7, address/tag width; the whole address is the tag (fully associative).
- WAYS, 4, number of ways; must be 4 (ages are 2 bits, ports are 4 bits).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- address  in  ADDR_W  lookup/update address.
- access  in  1  access valid; state updates at posedge when access=1 and busy=0.
- wren  in  1  access is a store; used only with CACHE_DIRTY_EN.
- flush  in  1  start invalidate-all; sampled only in IDLE.
- hit  out  WAYS  one-hot match (valid[i] && tag[i]==address); 0 on miss; forced 0 while busy.
- valido  out  WAYS  current valid bits.
- lruBit  out  WAYS  one-hot way whose age==WAYS-1.
- victimTag  out  ADDR_W  tag of the way flagged by lruBit (write-back address).
- busy  out  1  flush in progress.

Behaviour:
- State per way i: tag[i] (ADDR_W bits), valid[i], age[i] (2 bits). Ages always form a permutation of 0..3.
- Reset (synchronous, priority over everything):
  - tag=0, valid=0, age[i]=3-i, so way0 is LRU.
  - FSM=IDLE, busy=0.
  - Outputs after reset: hit=0000, valido=0000, lruBit=0001, victimTag=0.
- hit, valido, lruBit and victimTag are combinational from the registers and address, with zero latency, so the downstream selector sees them in the same cycle.
- Selected way s for an update, same priority as downstream:
  1. hit way, if any;
  2. otherwise the lowest-index invalid way;
  3. otherwise the lruBit way.
- Update at posedge when access=1 and FSM=IDLE:
  - tag[s]<=address, valid[s]<=1.
  - With a=age[s] (old value): age[s]<=0, and every way j with age[j]<a gets age[j]<=age[j]+1. All other ages hold.
  - A hit on the way that is already MRU (a=0) changes no ages.
- Multiple tag matches cannot occur because update rule 1 prevents duplicates. If a corrupted state produces one anyway, hit reports all matches and s is the lowest matching index.
- FSM IDLE/FLUSH, 2-bit way counter fc:
  - IDLE & flush=1 -> FLUSH with fc=0, busy=1. flush has priority over access in the same cycle, and that access is dropped.
  - In FLUSH, each cycle: valid[fc]<=0, fc<=fc+1. On fc=3, return to IDLE and busy<=0.
  - busy is high for exactly 4 cycles. Tags and ages are untouched by the flush.
  - access is ignored in FLUSH; flush re-asserted in FLUSH is ignored.
- Reset asserted mid-flush aborts the flush to the full reset state.
- The downstream wrenRam requirement (all valid and no hit) is met by construction: valido==1111 only after four distinct fills.

Optional Feature:
- Macro: CACHE_DIRTY_EN.
- With the macro defined:
  - Adds a dirty[i] bit per way and an output port victimDirty (out, 1) = dirty of the lruBit way.
  - On update: dirty[s]<=wren on a miss fill; dirty[s]<=dirty[s]|wren on a hit.
  - Reset and flush clear dirty.
- Without the macro: no dirty state, no victimDirty port; wren is unused.

Test Plan:
- Reset, then idle -> hit=0000, valido=0000, lruBit=0001, busy=0.
- Accesses to addresses 0x10, 0x20, 0x30, 0x40 -> valido steps 0001, 0011, 0111, 1111. Ages become way0=3, way1=2, way2=1, way3=0, and lruBit=0001 with victimTag=0x10.
- From the full state, access 0x10 (hit=0001) -> lruBit becomes 0010. Then access 0x50 (miss) -> way1 is replaced (tag=0x50) and lruBit=0100.
- Assert flush together with access 0x60 -> the access is dropped; busy=1 for 4 cycles; valido goes 1110, 1100, 1000, 0000; hit stays 0000 during busy.
- Assert reset during the 2nd flush cycle -> next cycle shows the full reset values and busy=0.
- With CACHE_DIRTY_EN: fill way0 with wren=1, fill ways 1-3 with wren=0 -> victimDirty=1 while lruBit=0001. Then read-hit way0 -> victimDirty=0 (lruBit=0010 now points at clean way1).

Source files
------------

// File: rtl/cache_tag_lru.sv
// cache_tag_lru: tag/valid/age store for a 4-way fully associative cache.
// Define CACHE_DIRTY_EN to add per-way dirty bits and the victimDirty output.
module cache_tag_lru #(
  parameter int ADDR_W = 7,
  parameter int WAYS   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              access,
  input  logic              wren,
  input  logic              flush,
  output logic [WAYS-1:0]   hit,
  output logic [WAYS-1:0]   valido,
  output logic [WAYS-1:0]   lruBit,
  output logic [ADDR_W-1:0] victimTag,
`ifdef CACHE_DIRTY_EN
  output logic              victimDirty,
`endif
  output logic              busy
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [ADDR_W-1:0] r_tag [WAYS];
  logic [1:0]        r_age [WAYS];
  logic [WAYS-1:0]   r_valid;
  logic [0:0]        r_state;
  logic [1:0]        r_fc;

  logic [WAYS-1:0]   w_match;
  logic [WAYS-1:0]   w_lru;
  logic [ADDR_W-1:0] w_vtag;
  logic [1:0]        w_sel;
  logic              w_sel_hit;
  logic [1:0]        w_sel_age;
  logic              w_busy;

  assign w_busy    = (r_state == S_FLUSH);
  assign w_sel_hit = |w_match;
  assign w_sel_age = r_age[w_sel];

  always_comb begin
    w_match = '0;
    w_lru   = '0;
    w_vtag  = '0;
    for (int i = 0; i < WAYS; i++) begin
      w_match[i] = r_valid[i] && (r_tag[i] == address);
      w_lru[i]   = (r_age[i] == 2'(WAYS-1));
    end
    for (int i = 0; i < WAYS; i++) begin
      if (r_age[i] == 2'(WAYS-1))
        w_vtag = r_tag[i];
    end
  end

  // Later loops override earlier ones: hit beats invalid beats LRU,
  // and descending order makes the lowest index win inside each rank.
  always_comb begin
    w_sel = '0;
    for (int i = WAYS-1; i >= 0; i--)
      if (w_lru[i]) w_sel = 2'(i);
    for (int i = WAYS-1; i >= 0; i--)
      if (!r_valid[i]) w_sel = 2'(i);
    for (int i = WAYS-1; i >= 0; i--)
      if (w_match[i]) w_sel = 2'(i);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_fc    <= '0;
      r_valid <= '0;
      for (int i = 0; i < WAYS; i++) begin
        r_tag[i] <= '0;
        r_age[i] <= 2'(WAYS-1-i);
      end
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (flush) begin
            r_state <= S_FLUSH;
            r_fc    <= '0;
          end else if (access) begin
            r_tag[w_sel]   <= address;
            r_valid[w_sel] <= 1'b1;
            for (int j = 0; j < WAYS; j++) begin
              if (2'(j) == w_sel)
                r_age[j] <= 2'd0;
              else if (r_age[j] < w_sel_age)
                r_age[j] <= r_age[j] + 2'd1;
            end
          end
        end
        S_FLUSH: begin
          r_valid[r_fc] <= 1'b0;
          r_fc          <= r_fc + 2'd1;
          if (r_fc == 2'(WAYS-1))
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CACHE_DIRTY_EN
  logic [WAYS-1:0] r_dirty;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_dirty <= '0;
    end else if (w_busy) begin
      r_dirty[r_fc] <= 1'b0;
    end else if (!flush && access) begin
      r_dirty[w_sel] <= wren | (w_sel_hit & r_dirty[w_sel]);
    end
  end

  assign victimDirty = |(w_lru & r_dirty);
`else
  logic w_unused_wren;
  assign w_unused_wren = wren;
`endif

  assign hit       = w_busy ? '0 : w_match;
  assign valido    = r_valid;
  assign lruBit    = w_lru;
  assign victimTag = w_vtag;
  assign busy      = w_busy;

endmodule

// File: tb/tb_cache_tag_lru.sv
// tb_cache_tag_lru: scoreboard bench for cache_tag_lru.
// Inputs change on negedge; outputs are sampled 1ns later.
module tb_cache_tag_lru;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       access = 1'b0;
  logic       wren = 1'b0;
  logic       flush = 1'b0;
  logic [6:0] address = '0;
  logic [3:0] hit, valido, lruBit;
  logic [6:0] victimTag;
  logic       busy;
`ifdef CACHE_DIRTY_EN
  logic       victimDirty;
`endif

  int nvec = 0;
  int nerr = 0;
  logic [19:0] sb [$];
  logic [19:0] got, exp_v;

  typedef struct packed {
    logic       r, acc, fl, wr;
    logic [6:0] a;
    logic [19:0] e;
  } row_t;

  // reference model state
  logic [6:0] mt [4];
  logic [1:0] ma [4];
  logic [3:0] mv;
  logic       mbusy;
  logic [1:0] mfc;

  always #5 clock = ~clock;

  cache_tag_lru #(.ADDR_W(7), .WAYS(4)) dut (
    .clock(clock), .reset(reset), .address(address),
    .access(access), .wren(wren), .flush(flush),
    .hit(hit), .valido(valido), .lruBit(lruBit),
    .victimTag(victimTag),
`ifdef CACHE_DIRTY_EN
    .victimDirty(victimDirty),
`endif
    .busy(busy)
  );

  assign got = {hit, valido, lruBit, victimTag, busy};

  function automatic logic [19:0] pk(logic [3:0] h, logic [3:0] v,
                                     logic [3:0] l, logic [6:0] vt,
                                     logic b);
    return {h, v, l, vt, b};
  endfunction

  function automatic row_t row(logic r, logic acc, logic fl, logic wr,
                               logic [6:0] a, logic [3:0] h,
                               logic [3:0] v, logic [3:0] l,
                               logic [6:0] vt, logic b);
    row_t x;
    x.r = r; x.acc = acc; x.fl = fl; x.wr = wr; x.a = a;
    x.e = pk(h, v, l, vt, b);
    return x;
  endfunction

  task automatic drive(input logic r, input logic acc, input logic fl,
                       input logic wr, input logic [6:0] a);
    @(negedge clock);
    reset = r; access = acc; flush = fl; wren = wr; address = a;
  endtask

  task automatic test_reset;
    row_t t[$];
    drive(1, 0, 0, 0, 7'h00);
    t.push_back(row(0,0,0,0,7'h00, 4'h0,4'h0,4'h1,7'h00,0));
    t.push_back(row(0,0,0,0,7'h10, 4'h0,4'h0,4'h1,7'h00,0));
    foreach (t[i]) begin
      drive(t[i].r, t[i].acc, t[i].fl, t[i].wr, t[i].a);
      sb.push_back(t[i].e);
      #1;
      exp_v = sb.pop_front();
      nvec++;
      if (got !== exp_v) begin
        nerr++;
        $display("FAIL reset[%0d] got=%h exp=%h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_fill;
    row_t t[$];
    t.push_back(row(0,1,0,0,7'h10, 4'h0,4'h0,4'h1,7'h00,0));
    t.push_back(row(0,1,0,0,7'h20, 4'h0,4'h1,4'h2,7'h00,0));
    t.push_back(row(0,1,0,0,7'h30, 4'h0,4'h3,4'h4,7'h00,0));
    t.push_back(row(0,1,0,0,7'h40, 4'h0,4'h7,4'h8,7'h00,0));
    t.push_back(row(0,0,0,0,7'h40, 4'h8,4'hF,4'h1,7'h10,0));
    foreach (t[i]) begin
      drive(t[i].r, t[i].acc, t[i].fl, t[i].wr, t[i].a);
      sb.push_back(t[i].e);
      #1;
      exp_v = sb.pop_front();
      nvec++;
      if (got !== exp_v) begin
        nerr++;
        $display("FAIL fill[%0d] got=%h exp=%h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_hit_replace;
    row_t t[$];
    t.push_back(row(0,1,0,0,7'h10, 4'h1,4'hF,4'h1,7'h10,0));
    t.push_back(row(0,1,0,0,7'h50, 4'h0,4'hF,4'h2,7'h20,0));
    t.push_back(row(0,1,0,0,7'h50, 4'h2,4'hF,4'h4,7'h30,0));
    t.push_back(row(0,0,0,0,7'h50, 4'h2,4'hF,4'h4,7'h30,0));
    foreach (t[i]) begin
      drive(t[i].r, t[i].acc, t[i].fl, t[i].wr, t[i].a);
      sb.push_back(t[i].e);
      #1;
      exp_v = sb.pop_front();
      nvec++;
      if (got !== exp_v) begin
        nerr++;
        $display("FAIL hit_replace[%0d] got=%h exp=%h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_flush;
    row_t t[$];
    t.push_back(row(0,1,1,0,7'h60, 4'h0,4'hF,4'h4,7'h30,0));
    t.push_back(row(0,1,1,0,7'h10, 4'h0,4'hF,4'h4,7'h30,1));
    t.push_back(row(0,1,1,0,7'h10, 4'h0,4'hE,4'h4,7'h30,1));
    t.push_back(row(0,1,1,0,7'h10, 4'h0,4'hC,4'h4,7'h30,1));
    t.push_back(row(0,1,1,0,7'h10, 4'h0,4'h8,4'h4,7'h30,1));
    t.push_back(row(0,0,0,0,7'h10, 4'h0,4'h0,4'h4,7'h30,0));
    foreach (t[i]) begin
      drive(t[i].r, t[i].acc, t[i].fl, t[i].wr, t[i].a);
      sb.push_back(t[i].e);
      #1;
      exp_v = sb.pop_front();
      nvec++;
      if (got !== exp_v) begin
        nerr++;
        $display("FAIL flush[%0d] got=%h exp=%h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_flush;
    row_t t[$];
    t.push_back(row(0,1,0,0,7'h11, 4'h0,4'h0,4'h4,7'h30,0));
    t.push_back(row(0,1,0,0,7'h22, 4'h0,4'h1,4'h4,7'h30,0));
    t.push_back(row(0,0,1,0,7'h11, 4'h1,4'h3,4'h4,7'h30,0));
    t.push_back(row(0,0,0,0,7'h11, 4'h0,4'h3,4'h4,7'h30,1));
    t.push_back(row(1,0,0,0,7'h11, 4'h0,4'h2,4'h4,7'h30,1));
    t.push_back(row(0,0,0,0,7'h11, 4'h0,4'h0,4'h1,7'h00,0));
    t.push_back(row(0,0,0,0,7'h11, 4'h0,4'h0,4'h1,7'h00,0));
    foreach (t[i]) begin
      drive(t[i].r, t[i].acc, t[i].fl, t[i].wr, t[i].a);
      sb.push_back(t[i].e);
      #1;
      exp_v = sb.pop_front();
      nvec++;
      if (got !== exp_v) begin
        nerr++;
        $display("FAIL reset_mid_flush[%0d] got=%h exp=%h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic       acc, fl;
    logic [6:0] a;
    logic [3:0] mh, ml;
    logic [6:0] mvt;
    logic [1:0] old;
    int         s;
    drive(1, 0, 0, 0, 7'h00);
    mv = '0; mbusy = 1'b0; mfc = '0;
    for (int i = 0; i < 4; i++) begin
      mt[i] = '0;
      ma[i] = 2'(3 - i);
    end
    for (int n = 0; n < 400; n++) begin
      acc = ($urandom_range(0, 9) < 8);
      fl  = ($urandom_range(0, 39) == 0);
      a   = 7'($urandom_range(1, 6));
      mh = '0; ml = '0; mvt = '0;
      for (int i = 0; i < 4; i++) begin
        if (mv[i] && mt[i] == a) mh[i] = 1'b1;
        if (ma[i] == 2'd3) begin
          ml[i] = 1'b1;
          mvt = mt[i];
        end
      end
      drive(0, acc, fl, 1'($urandom_range(0, 1)), a);
      sb.push_back(pk(mbusy ? 4'h0 : mh, mv, ml, mvt, mbusy));
      #1;
      exp_v = sb.pop_front();
      nvec++;
      if (got !== exp_v) begin
        nerr++;
        $display("FAIL back_to_back[%0d] got=%h exp=%h", n, got, exp_v);
      end
      if (mbusy) begin
        mv[mfc] = 1'b0;
        if (mfc == 2'd3) mbusy = 1'b0;
        mfc = mfc + 2'd1;
      end else if (fl) begin
        mbusy = 1'b1;
        mfc = '0;
      end else if (acc) begin
        s = -1;
        for (int i = 0; i < 4; i++) if (s < 0 && mh[i]) s = i;
        for (int i = 0; i < 4; i++) if (s < 0 && !mv[i]) s = i;
        for (int i = 0; i < 4; i++) if (s < 0 && ml[i]) s = i;
        old = ma[s];
        for (int j = 0; j < 4; j++) begin
          if (j == s) ma[j] = 2'd0;
          else if (ma[j] < old) ma[j] = ma[j] + 2'd1;
        end
        mt[s] = a;
        mv[s] = 1'b1;
      end
    end
  endtask

`ifdef CACHE_DIRTY_EN
  task automatic test_dirty;
    logic [19:0] e[$];
    drive(1, 0, 0, 0, 7'h00);
    drive(0, 1, 0, 1, 7'h10);
    drive(0, 1, 0, 0, 7'h20);
    drive(0, 1, 0, 0, 7'h30);
    drive(0, 1, 0, 0, 7'h40);
    drive(0, 0, 0, 0, 7'h40);
    sb.push_back({15'd0, 4'h1, 1'b1});
    #1;
    e.push_back(sb.pop_front());
    nvec++;
    if ({15'd0, lruBit, victimDirty} !== e[0]) begin
      nerr++;
      $display("FAIL dirty_victim got=%h exp=%h", {lruBit, victimDirty}, e[0]);
    end
    drive(0, 1, 0, 0, 7'h10);
    drive(0, 0, 0, 0, 7'h10);
    sb.push_back({15'd0, 4'h2, 1'b0});
    #1;
    e.push_back(sb.pop_front());
    nvec++;
    if ({15'd0, lruBit, victimDirty} !== e[1]) begin
      nerr++;
      $display("FAIL dirty_clean got=%h exp=%h", {lruBit, victimDirty}, e[1]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_hit_replace();
    test_flush();
    test_reset_mid_flush();
    test_back_to_back();
`ifdef CACHE_DIRTY_EN
    test_dirty();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
